fifo_empty_rd: RTL and testbench

Read-side pointer and status controller for the 16-entry asynchronous FIFO. It is the read-domain counterpart of the write-side full/pointer logic. The block synchronises the incoming Gray-coded write pointer into the read clock domain and advances the read pointer on accepted reads. It produces the RAM read address, the Gray read pointer exported to the write domain, and registered empty, almost-empty, fill-level and underflow status.

---
 rtl/fifo_empty_rd.sv | 80 ++++++++
 tb/tb_fifo_empty_rd.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_empty_rd.sv
// Read-side pointer/status controller for a 16-entry async FIFO.
// Syncs the Gray write pointer and tracks the read pointer and fill status.
module fifo_empty_rd #(
  parameter int ADDR_W    = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_addr_grey,
  output logic [ADDR_W-1:0] rd_addr_bin,
  output logic [ADDR_W:0]   rd_addr_grey,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam logic [ADDR_W:0] LP_AE_TH = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W:0] r_wr_sync1;
  logic [ADDR_W:0] r_wr_sync2;
  logic [ADDR_W:0] r_rd_bin;
  logic [ADDR_W:0] r_rd_grey;
  logic [ADDR_W:0] r_level;
  logic            r_empty;
  logic            r_aempty;
  logic            r_underflow;

  logic [ADDR_W:0] w_wr_bin_sync;
  logic [ADDR_W:0] w_rd_bin_next;
  logic [ADDR_W:0] w_rd_grey_next;
  logic [ADDR_W:0] w_level_next;
  logic            w_rd_acc;
  logic            w_empty_next;

  always_comb begin
    w_wr_bin_sync = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_wr_bin_sync[i] = ^(r_wr_sync2 >> i);
    end
  end

  // Gating on the registered flag keeps reads from ever passing the writer.
  assign w_rd_acc       = rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + {{ADDR_W{1'b0}}, w_rd_acc};
  assign w_rd_grey_next = (w_rd_bin_next >> 1) ^ w_rd_bin_next;
  assign w_empty_next   = (w_rd_grey_next == r_wr_sync2);
  assign w_level_next   = w_wr_bin_sync - w_rd_bin_next;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      r_wr_sync1  <= '0;
      r_wr_sync2  <= '0;
      r_rd_bin    <= '0;
      r_rd_grey   <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_wr_sync1  <= wr_ptr_addr_grey;
      r_wr_sync2  <= r_wr_sync1;
      r_rd_bin    <= w_rd_bin_next;
      r_rd_grey   <= w_rd_grey_next;
      r_level     <= w_level_next;
      r_empty     <= w_empty_next;
      r_aempty    <= (w_level_next <= LP_AE_TH);
      r_underflow <= r_underflow | (rd_en & r_empty);
    end
  end

  assign rd_addr_bin  = r_rd_bin[ADDR_W-1:0];
  assign rd_addr_grey = r_rd_grey;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign rd_level     = r_level;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_empty_rd.sv
// Bench for fifo_empty_rd: directed scenarios plus randomized traffic
// checked against a counter-based occupancy model.
module tb_fifo_empty_rd;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       rd_en;
  logic [4:0] wr_ptr_addr_grey;
  logic [3:0] rd_addr_bin;
  logic [4:0] rd_addr_grey;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  fifo_empty_rd #(.ADDR_W(4), .AEMPTY_TH(2)) dut (
    .rd_clk           (rd_clk),
    .rd_rst           (rd_rst),
    .rd_en            (rd_en),
    .wr_ptr_addr_grey (wr_ptr_addr_grey),
    .rd_addr_bin      (rd_addr_bin),
    .rd_addr_grey     (rd_addr_grey),
    .empty            (empty),
    .almost_empty     (almost_empty),
    .rd_level         (rd_level),
    .underflow        (underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: entries written (m_w), entries read (m_r), both mod 32.
  // The reader sees the writer count two sampled edges late (wq).
  int m_w = 0;
  int m_r = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_ae = 1'b1;
  bit m_uf = 1'b0;
  int wq[$] = '{0, 0};

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic step(input bit en, input bit rst);
    int seen;
    bit acc;
    rd_en = en;
    rd_rst = rst;
    wr_ptr_addr_grey = gray(m_w);
    @(posedge rd_clk);
    if (!rst) begin
      m_r = 0;
      m_level = 0;
      m_empty = 1'b1;
      m_ae = 1'b1;
      m_uf = 1'b0;
      wq = '{0, 0};
    end else begin
      seen = wq[0];
      acc = en && !m_empty;
      m_uf = m_uf | (en & m_empty);
      m_r = (m_r + int'(acc)) % 32;
      m_level = (seen - m_r + 32) % 32;
      m_empty = (m_level == 0);
      m_ae = (m_level <= 2);
      void'(wq.pop_front());
      wq.push_back(m_w % 32);
    end
    #1;
  endtask

  task automatic test_reset();
    m_w = 6;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_checks++;
    if (rd_addr_bin !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_addr got=%0d exp=0", rd_addr_bin);
    end
    n_checks++;
    if (rd_addr_grey !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_grey got=%b exp=0", rd_addr_grey);
    end
    n_checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_flags got=%b%b exp=11", empty, almost_empty);
    end
    n_checks++;
    if (rd_level !== 5'd0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_lvl_uf got=%0d/%b exp=0/0", rd_level, underflow);
    end
  endtask

  task automatic test_single();
    m_w = 0;
    step(1'b0, 1'b0);
    m_w = 1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_checks++;
    if (empty !== 1'b1) begin
      n_errors++;
      $display("FAIL single_edge2_empty got=%b exp=1", empty);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (empty !== 1'b0 || rd_level !== 5'd1) begin
      n_errors++;
      $display("FAIL single_edge3 got=%b/%0d exp=0/1", empty, rd_level);
    end
    step(1'b1, 1'b1);
    n_checks++;
    if (rd_addr_bin !== 4'd1 || rd_addr_grey !== 5'b00001) begin
      n_errors++;
      $display("FAIL single_rd_ptr got=%0d/%b exp=1/00001",
               rd_addr_bin, rd_addr_grey);
    end
    n_checks++;
    if (empty !== 1'b1 || rd_level !== 5'd0) begin
      n_errors++;
      $display("FAIL single_rd_flags got=%b/%0d exp=1/0", empty, rd_level);
    end
  endtask

  task automatic test_full_drain();
    m_w = 0;
    step(1'b0, 1'b0);
    m_w = 16;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_checks++;
    if (rd_level !== 5'd16 || almost_empty !== 1'b0) begin
      n_errors++;
      $display("FAIL full_level got=%0d/%b exp=16/0", rd_level, almost_empty);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (rd_level !== 5'(15 - i) || almost_empty !== (15 - i <= 2)) begin
        n_errors++;
        $display("FAIL drain_%0d got=%0d/%b exp=%0d/%b", i, rd_level,
                 almost_empty, 15 - i, (15 - i <= 2));
      end
    end
    n_checks++;
    if (rd_addr_bin !== 4'd0 || rd_addr_grey !== 5'b11000
        || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_end got=%0d/%b/%b exp=0/11000/1",
               rd_addr_bin, rd_addr_grey, empty);
    end
  endtask

  task automatic test_wrap();
    m_w = 31;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_checks++;
    if (rd_level !== 5'd15) begin
      n_errors++;
      $display("FAIL wrap_level got=%0d exp=15", rd_level);
    end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    n_checks++;
    if (rd_addr_grey !== 5'b10000 || empty !== 1'b1
        || rd_addr_bin !== 4'd15) begin
      n_errors++;
      $display("FAIL wrap_end got=%b/%b/%0d exp=10000/1/15",
               rd_addr_grey, empty, rd_addr_bin);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b1);
    n_checks++;
    if (underflow !== 1'b1 || rd_addr_grey !== 5'b10000) begin
      n_errors++;
      $display("FAIL uf_set got=%b/%b exp=1/10000", underflow, rd_addr_grey);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_checks++;
    if (underflow !== 1'b1 || rd_level !== 5'd0) begin
      n_errors++;
      $display("FAIL uf_sticky got=%b/%0d exp=1/0", underflow, rd_level);
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL uf_clear got=%b exp=0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    m_w = 16;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    n_checks++;
    if (rd_level !== 5'd8) begin
      n_errors++;
      $display("FAIL mid_level got=%0d exp=8", rd_level);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (rd_addr_grey !== 5'd0 || empty !== 1'b1 || rd_level !== 5'd0) begin
      n_errors++;
      $display("FAIL mid_rst got=%b/%b/%0d exp=0/1/0",
               rd_addr_grey, empty, rd_level);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_checks++;
    if (empty !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_early got=%b exp=1", empty);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (rd_level !== 5'd16 || empty !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_recover got=%0d/%b exp=16/0", rd_level, empty);
    end
  endtask

  task automatic test_random();
    int occ;
    bit en;
    bit rst;
    m_w = $urandom_range(0, 31);
    step(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      occ = (m_w - m_r + 32) % 32;
      if (occ < 16) m_w = (m_w + $urandom_range(0, (16 - occ > 2) ? 2 : 1)) % 32;
      en = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) != 0);
      step(en, rst);
      n_checks++;
      if (rd_addr_grey !== gray(m_r) || rd_addr_bin !== 4'(m_r % 16)) begin
        n_errors++;
        $display("FAIL rnd_ptr c%0d got=%b/%0d exp=%b/%0d", i, rd_addr_grey,
                 rd_addr_bin, gray(m_r), m_r % 16);
      end
      n_checks++;
      if (rd_level !== 5'(m_level) || empty !== m_empty) begin
        n_errors++;
        $display("FAIL rnd_lvl c%0d got=%0d/%b exp=%0d/%b", i, rd_level,
                 empty, m_level, m_empty);
      end
      n_checks++;
      if (almost_empty !== m_ae || underflow !== m_uf) begin
        n_errors++;
        $display("FAIL rnd_flags c%0d got=%b/%b exp=%b/%b", i,
                 almost_empty, underflow, m_ae, m_uf);
      end
    end
  endtask

  initial begin
    rd_rst = 1'b0;
    rd_en = 1'b0;
    wr_ptr_addr_grey = '0;
    @(negedge rd_clk);
    test_reset();
    test_single();
    test_full_drain();
    test_wrap();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
